// File: rtl/instr_fetch_ir_pkg.sv
// Shared definitions for the fetch unit: FSM state encodings, the reset NOP word and
// instruction field bit positions, also reused by the decoder and microcode ROM.
package instr_fetch_ir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

endpackage

// File: rtl/instr_fetch_ir_field_split.sv
// Combinational split of the instruction register into the standard RISC-V fields.
module ir_field_split
    import instr_fetch_ir_pkg::*;
(
    input  logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign funct3 = ir[F3_MSB:F3_LSB];
    assign rs1    = ir[RS1_MSB:RS1_LSB];
    assign rs2    = ir[RS2_MSB:RS2_LSB];
    assign funct7 = ir[F7_MSB:F7_LSB];

endmodule

// File: rtl/instr_fetch_ir.sv
// Fetch unit and instruction register: fetches one word at the PC over a req/rdy
// handshake (or loads it from the shared bus) and exposes the decoded IR fields.
module instr_fetch_ir
    import instr_fetch_ir_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_IR    = NOP_INSTR,
    parameter int          TIMEOUT_CYC = 16,
    parameter int          CNT_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_start,
    input  logic [XLEN-1:0] pc_in,
    input  logic            ld_ir,
    input  logic [XLEN-1:0] bus_in,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rd_req,
    input  logic            mem_rdy,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] ir_out,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            ir_valid,
    output logic            fetch_busy,
    output logic            fetch_done,
    output logic            misalign_err,
    output logic            timeout_err,
    output logic [1:0]      dbg_state
);

    // Handshake: mem_rd_req stays high with mem_addr frozen for the whole WAIT state;
    // the word transfers on any rising edge where mem_rd_req and mem_rdy are both high.
    // mem_rdy is meaningless while mem_rd_req is low and is ignored then.

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    fetch_state_t     state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             start_ok, misalign, timeout, load_mem, load_bus;

    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        misalign   = 1'b0;
        timeout    = 1'b0;
        load_mem   = 1'b0;
        load_bus   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch_start) begin
                    if (pc_in[1:0] != 2'b00) begin
                        misalign = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        next_state = ST_WAIT;
                    end
                end else if (ld_ir) begin
                    load_bus = 1'b1;
                end
            end
            ST_WAIT: begin
                // A response on the last allowed cycle still completes the fetch.
                if (mem_rdy) begin
                    load_mem   = 1'b1;
                    next_state = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mem_addr     <= '0;
            ir_out       <= XLEN'(RESET_IR);
            ir_valid     <= 1'b0;
            mem_rd_req   <= 1'b0;
            fetch_busy   <= 1'b0;
            fetch_done   <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= next_state;
            mem_rd_req   <= (next_state == ST_WAIT);
            fetch_busy   <= (next_state != ST_IDLE);
            fetch_done   <= (next_state == ST_DONE);
            misalign_err <= misalign;
            timeout_err  <= timeout;
            if (start_ok) begin
                mem_addr <= pc_in;
                ir_valid <= 1'b0;
                cnt      <= '0;
            end
            if (state == ST_WAIT && !mem_rdy && !timeout) begin
                cnt <= cnt + 1'b1;
            end
            if (load_mem) begin
                ir_out   <= mem_rdata;
                ir_valid <= 1'b1;
            end
            if (load_bus) begin
                ir_out   <= bus_in;
                ir_valid <= 1'b1;
            end
        end
    end

    assign dbg_state = state;

    ir_field_split u_split (
        .ir     (ir_out[31:0]),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7)
    );

endmodule

// File: tb/tb_instr_fetch_ir.sv
// Directed bench for instr_fetch_ir: reset, normal fetch, misalignment, timeout,
// last-cycle response, ld_ir priority, stray mem_rdy and reset in the middle of a fetch.
module tb_instr_fetch_ir;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [31:0] pc_in;
    logic        ld_ir;
    logic [31:0] bus_in;
    logic [31:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic [31:0] ir_out;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        ir_valid, fetch_busy, fetch_done, misalign_err, timeout_err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_ir dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_start  (fetch_start),
        .pc_in        (pc_in),
        .ld_ir        (ld_ir),
        .bus_in       (bus_in),
        .mem_addr     (mem_addr),
        .mem_rd_req   (mem_rd_req),
        .mem_rdy      (mem_rdy),
        .mem_rdata    (mem_rdata),
        .ir_out       (ir_out),
        .opcode       (opcode),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct3       (funct3),
        .funct7       (funct7),
        .ir_valid     (ir_valid),
        .fetch_busy   (fetch_busy),
        .fetch_done   (fetch_done),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .dbg_state    (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1; fetch_start = 1'b0; pc_in = '0; ld_ir = 1'b0;
        bus_in = '0; mem_rdy = 1'b0; mem_rdata = '0;

        // Reset
        tick(); tick();
        chk("rst_ir", ir_out, 32'h0000_0013);
        chk("rst_opcode", 32'(opcode), 32'h13);
        chk("rst_req", 32'(mem_rd_req), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Normal fetch, memory answers on the third WAIT cycle
        fetch_start = 1'b1; pc_in = 32'h100;
        tick();
        fetch_start = 1'b0;
        chk("f1_req", 32'(mem_rd_req), 32'd1);
        chk("f1_addr", mem_addr, 32'h100);
        chk("f1_busy", 32'(fetch_busy), 32'd1);
        chk("f1_valid", 32'(ir_valid), 32'd0);
        chk("f1_state", 32'(dbg_state), 32'd1);
        tick(); tick();
        chk("f1_req_hold", 32'(mem_rd_req), 32'd1);
        chk("f1_addr_hold", mem_addr, 32'h100);
        mem_rdy = 1'b1; mem_rdata = 32'h00A0_0093;
        tick();
        mem_rdy = 1'b0; mem_rdata = '0;
        chk("f1_done", 32'(fetch_done), 32'd1);
        chk("f1_ir", ir_out, 32'h00A0_0093);
        chk("f1_rd", 32'(rd), 32'd1);
        chk("f1_opcode", 32'(opcode), 32'h13);
        chk("f1_rs1", 32'(rs1), 32'd0);
        chk("f1_rs2", 32'(rs2), 32'h0A);
        chk("f1_funct3", 32'(funct3), 32'd0);
        chk("f1_funct7", 32'(funct7), 32'd0);
        chk("f1_valid2", 32'(ir_valid), 32'd1);
        chk("f1_req_low", 32'(mem_rd_req), 32'd0);
        tick();
        chk("f1_done_pulse", 32'(fetch_done), 32'd0);
        chk("f1_idle", 32'(fetch_busy), 32'd0);

        // Misaligned fetch
        fetch_start = 1'b1; pc_in = 32'h102;
        tick();
        fetch_start = 1'b0;
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_req", 32'(mem_rd_req), 32'd0);
        chk("mis_busy", 32'(fetch_busy), 32'd0);
        chk("mis_ir", ir_out, 32'h00A0_0093);
        chk("mis_valid", 32'(ir_valid), 32'd1);
        chk("mis_addr", mem_addr, 32'h100);
        tick();
        chk("mis_pulse", 32'(misalign_err), 32'd0);
        chk("mis_req2", 32'(mem_rd_req), 32'd0);

        // Timeout after 16 WAIT cycles with no response
        fetch_start = 1'b1; pc_in = 32'h200;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_busy15", 32'(fetch_busy), 32'd1);
        chk("to_req15", 32'(mem_rd_req), 32'd1);
        chk("to_err15", 32'(timeout_err), 32'd0);
        tick();
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_busy", 32'(fetch_busy), 32'd0);
        chk("to_req", 32'(mem_rd_req), 32'd0);
        chk("to_valid", 32'(ir_valid), 32'd0);
        chk("to_ir", ir_out, 32'h00A0_0093);
        chk("to_done", 32'(fetch_done), 32'd0);
        tick();
        chk("to_pulse", 32'(timeout_err), 32'd0);

        // Response on the 16th WAIT cycle beats the timeout
        fetch_start = 1'b1; pc_in = 32'h300;
        tick();
        fetch_start = 1'b0;
        chk("late_addr", mem_addr, 32'h300);
        for (int i = 0; i < 15; i++) tick();
        mem_rdy = 1'b1; mem_rdata = 32'h40B5_0533;
        tick();
        mem_rdy = 1'b0; mem_rdata = '0;
        chk("late_done", 32'(fetch_done), 32'd1);
        chk("late_noto", 32'(timeout_err), 32'd0);
        chk("late_ir", ir_out, 32'h40B5_0533);
        chk("late_opcode", 32'(opcode), 32'h33);
        chk("late_rd", 32'(rd), 32'h0A);
        chk("late_rs1", 32'(rs1), 32'h0A);
        chk("late_rs2", 32'(rs2), 32'h0B);
        chk("late_funct7", 32'(funct7), 32'h20);
        chk("late_valid", 32'(ir_valid), 32'd1);
        tick();
        chk("late_noto2", 32'(timeout_err), 32'd0);

        // fetch_start wins over ld_ir; commands during WAIT are ignored
        fetch_start = 1'b1; ld_ir = 1'b1; pc_in = 32'h400; bus_in = 32'hFFF0_0113;
        tick();
        chk("pri_busy", 32'(fetch_busy), 32'd1);
        chk("pri_req", 32'(mem_rd_req), 32'd1);
        chk("pri_ir", ir_out, 32'h40B5_0533);
        chk("pri_valid", 32'(ir_valid), 32'd0);
        chk("pri_addr", mem_addr, 32'h400);
        pc_in = 32'h500;
        tick();
        fetch_start = 1'b0; ld_ir = 1'b0;
        chk("wait_addr", mem_addr, 32'h400);
        chk("wait_ir", ir_out, 32'h40B5_0533);
        mem_rdy = 1'b1; mem_rdata = 32'h0020_8033;
        tick();
        mem_rdy = 1'b0;
        chk("pri_done", 32'(fetch_done), 32'd1);
        chk("pri_ir2", ir_out, 32'h0020_8033);
        tick();
        ld_ir = 1'b1;
        tick();
        ld_ir = 1'b0;
        chk("ld_ir", ir_out, 32'hFFF0_0113);
        chk("ld_valid", 32'(ir_valid), 32'd1);
        chk("ld_busy", 32'(fetch_busy), 32'd0);
        chk("ld_rd", 32'(rd), 32'd2);
        chk("ld_funct7", 32'(funct7), 32'h7F);
        chk("ld_rs2", 32'(rs2), 32'h1F);

        // Stray mem_rdy in IDLE is ignored
        mem_rdy = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rdy = 1'b0;
        chk("stray_ir", ir_out, 32'hFFF0_0113);
        chk("stray_done", 32'(fetch_done), 32'd0);
        chk("stray_busy", 32'(fetch_busy), 32'd0);

        // Reset on the second WAIT cycle, late response afterwards
        fetch_start = 1'b1; pc_in = 32'h600;
        tick();
        fetch_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_req", 32'(mem_rd_req), 32'd0);
        chk("mid_ir", ir_out, 32'h0000_0013);
        chk("mid_busy", 32'(fetch_busy), 32'd0);
        mem_rdy = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        tick();
        mem_rdy = 1'b0;
        chk("mid_ir2", ir_out, 32'h0000_0013);
        chk("mid_done", 32'(fetch_done), 32'd0);
        chk("mid_valid", 32'(ir_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
